tl45_decode: RTL and testbench

Instruction decode stage of the tl45 core. It sits directly downstream of the prefetch stage and consumes its `o_buf_pc`/`o_buf_inst` buffer, where an all-zero instruction word means "no instruction". It splits each 32-bit word into register fields, opcode class and a 32-bit extended immediate, and holds the result in a one-entry output register for the execute stage. Downstream stall is propagated back to prefetch; flush empties the stage.

---
 rtl/tl45_decode.sv | 122 ++++++++++++
 tb/tb_tl45_decode.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/tl45_decode.sv
// tl45 decode stage: splits a prefetched instruction word into register fields,
// opcode class and extended immediate, held in a one-entry register for execute.
module tl45_decode #(
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_pipe_stall,
  input  logic        i_pipe_flush,
  input  logic [31:0] i_buf_pc,
  input  logic [31:0] i_buf_inst,
  output logic        o_pipe_stall,
  output logic        o_valid,
  output logic [31:0] o_pc,
  output logic [4:0]  o_opcode,
  output logic [1:0]  o_class,
  output logic [3:0]  o_dr,
  output logic [3:0]  o_sr1,
  output logic [3:0]  o_sr2,
  output logic        o_use_imm,
  output logic [31:0] o_imm
);

  localparam logic [1:0] CLS_ALU    = 2'd0;
  localparam logic [1:0] CLS_MEM    = 2'd1;
  localparam logic [1:0] CLS_BRANCH = 2'd2;
  localparam logic [1:0] CLS_ILL    = 2'd3;

  logic        r_valid;
  logic [31:0] r_pc;
  logic [4:0]  r_opcode;
  logic [1:0]  r_class;
  logic [3:0]  r_dr;
  logic [3:0]  r_sr1;
  logic [3:0]  r_sr2;
  logic        r_use_imm;
  logic [31:0] r_imm;

  logic [4:0]  w_opcode;
  logic        w_imm_form;
  logic        w_bubble;
  logic        w_legal;
  logic        w_hold;
  logic [1:0]  w_class;
  logic [15:0] w_imm16;
  logic [31:0] w_imm_ext;

  assign w_opcode   = i_buf_inst[31:27];
  assign w_imm_form = i_buf_inst[26];
  assign w_imm16    = i_buf_inst[15:0];
  assign w_bubble   = (i_buf_inst == 32'h0);
  assign w_legal    = (w_class != CLS_ILL);
  assign w_hold     = r_valid && i_pipe_stall;

  always_comb begin
    w_class = CLS_ILL;
    if (w_opcode >= 5'h01 && w_opcode <= 5'h07)
      w_class = CLS_ALU;
    else if (w_opcode == 5'h08 || w_opcode == 5'h09)
      w_class = CLS_MEM;
    else if (w_opcode >= 5'h0A && w_opcode <= 5'h0C)
      w_class = CLS_BRANCH;
  end

  // H (bit 17) takes priority over Z (bit 16)
  always_comb begin
    w_imm_ext = {{16{w_imm16[15]}}, w_imm16};
    if (i_buf_inst[17])
      w_imm_ext = {w_imm16, 16'h0};
    else if (i_buf_inst[16])
      w_imm_ext = {16'h0, w_imm16};
  end

  always_ff @(posedge i_clk) begin
    if (i_reset || i_pipe_flush) begin
      r_valid   <= 1'b0;
      r_pc      <= RESET_PC;
      r_opcode  <= 5'h0;
      r_class   <= 2'd0;
      r_dr      <= 4'h0;
      r_sr1     <= 4'h0;
      r_sr2     <= 4'h0;
      r_use_imm <= 1'b0;
      r_imm     <= 32'h0;
    end else if (!w_hold) begin
      if (w_bubble) begin
        r_valid   <= 1'b0;
        r_pc      <= RESET_PC;
        r_opcode  <= 5'h0;
        r_class   <= 2'd0;
        r_dr      <= 4'h0;
        r_sr1     <= 4'h0;
        r_sr2     <= 4'h0;
        r_use_imm <= 1'b0;
        r_imm     <= 32'h0;
      end else begin
        // illegal words still issue so execute can trap with the right PC
        r_valid   <= 1'b1;
        r_pc      <= i_buf_pc;
        r_opcode  <= w_opcode;
        r_class   <= w_class;
        r_dr      <= w_legal ? i_buf_inst[25:22] : 4'h0;
        r_sr1     <= w_legal ? i_buf_inst[21:18] : 4'h0;
        r_sr2     <= (w_legal && !w_imm_form) ? i_buf_inst[17:14] : 4'h0;
        r_use_imm <= w_legal && w_imm_form;
        r_imm     <= (w_legal && w_imm_form) ? w_imm_ext : 32'h0;
      end
    end
  end

  assign o_pipe_stall = i_pipe_stall && r_valid;
  assign o_valid      = r_valid;
  assign o_pc         = r_pc;
  assign o_opcode     = r_opcode;
  assign o_class      = r_class;
  assign o_dr         = r_dr;
  assign o_sr1        = r_sr1;
  assign o_sr2        = r_sr2;
  assign o_use_imm    = r_use_imm;
  assign o_imm        = r_imm;

endmodule

// File: tb/tb_tl45_decode.sv
// Bench for tl45_decode: fixed decode vectors, hand-built stall/flush/reset
// sequences, then random traffic against a cycle-level reference model.
module tb_tl45_decode;

  localparam logic [31:0] RPC = 32'hFFFF_0040;

  logic        clk = 1'b0;
  logic        i_reset = 1'b0, i_pipe_stall = 1'b0, i_pipe_flush = 1'b0;
  logic [31:0] i_buf_pc = '0, i_buf_inst = '0;
  logic        o_pipe_stall, o_valid, o_use_imm;
  logic [31:0] o_pc, o_imm;
  logic [4:0]  o_opcode;
  logic [1:0]  o_class;
  logic [3:0]  o_dr, o_sr1, o_sr2;

  always #5 clk = ~clk;

  tl45_decode #(.RESET_PC(RPC)) dut (
    .i_clk(clk), .i_reset(i_reset), .i_pipe_stall(i_pipe_stall),
    .i_pipe_flush(i_pipe_flush), .i_buf_pc(i_buf_pc), .i_buf_inst(i_buf_inst),
    .o_pipe_stall(o_pipe_stall), .o_valid(o_valid), .o_pc(o_pc),
    .o_opcode(o_opcode), .o_class(o_class), .o_dr(o_dr), .o_sr1(o_sr1),
    .o_sr2(o_sr2), .o_use_imm(o_use_imm), .o_imm(o_imm)
  );

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [4:0]  opc;
    logic [1:0]  cls;
    logic [3:0]  dr, sr1, sr2;
    logic        use_imm;
    logic [31:0] imm;
  } dec_t;

  typedef struct {
    string       name;
    logic [31:0] pc;
    logic [31:0] inst;
    dec_t        exp;
  } vec_t;

  int   total = 0;
  int   bad = 0;
  dec_t m;

  function automatic dec_t mk(logic v, logic [31:0] pc, logic [4:0] opc, logic [1:0] cls,
                              logic [3:0] dr, logic [3:0] sr1, logic [3:0] sr2,
                              logic ui, logic [31:0] imm);
    dec_t d;
    d.valid = v; d.pc = pc; d.opc = opc; d.cls = cls;
    d.dr = dr; d.sr1 = sr1; d.sr2 = sr2; d.use_imm = ui; d.imm = imm;
    return d;
  endfunction

  function automatic dec_t empty_dec();
    return mk(1'b0, RPC, 5'd0, 2'd0, 4'd0, 4'd0, 4'd0, 1'b0, 32'd0);
  endfunction

  // reference decode straight from the encoding rules, using integer arithmetic
  function automatic dec_t ref_decode(logic [31:0] inst, logic [31:0] pc);
    dec_t        d;
    int unsigned opc, imm16;
    d = empty_dec();
    if (inst == 32'd0) return d;
    opc     = inst >> 27;
    d.valid = 1'b1;
    d.pc    = pc;
    d.opc   = 5'(opc);
    if (opc >= 1 && opc <= 7) d.cls = 2'd0;
    else if (opc == 8 || opc == 9) d.cls = 2'd1;
    else if (opc >= 10 && opc <= 12) d.cls = 2'd2;
    else begin
      d.cls = 2'd3;
      return d;
    end
    d.dr  = 4'((inst >> 22) % 16);
    d.sr1 = 4'((inst >> 18) % 16);
    if ((inst >> 26) % 2 == 1) begin
      d.use_imm = 1'b1;
      imm16 = inst % 65536;
      if ((inst >> 17) % 2 == 1)      d.imm = imm16 * 65536;
      else if ((inst >> 16) % 2 == 1) d.imm = imm16;
      else if (imm16 >= 32768)        d.imm = imm16 + 32'hFFFF_0000;
      else                            d.imm = imm16;
    end else begin
      d.sr2 = 4'((inst >> 14) % 16);
    end
    return d;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_out(input string tag, input dec_t e);
    chk({tag, ".valid"},   32'(o_valid),   32'(e.valid));
    chk({tag, ".pc"},      o_pc,           e.pc);
    chk({tag, ".opcode"},  32'(o_opcode),  32'(e.opc));
    chk({tag, ".class"},   32'(o_class),   32'(e.cls));
    chk({tag, ".dr"},      32'(o_dr),      32'(e.dr));
    chk({tag, ".sr1"},     32'(o_sr1),     32'(e.sr1));
    chk({tag, ".sr2"},     32'(o_sr2),     32'(e.sr2));
    chk({tag, ".use_imm"}, 32'(o_use_imm), 32'(e.use_imm));
    chk({tag, ".imm"},     o_imm,          e.imm);
  endtask

  // one cycle: drive at negedge, check stall combinationally, advance model, check after edge
  task automatic step(input logic rst, input logic fl, input logic st,
                      input logic [31:0] pc, input logic [31:0] inst);
    @(negedge clk);
    i_reset = rst; i_pipe_flush = fl; i_pipe_stall = st;
    i_buf_pc = pc; i_buf_inst = inst;
    #1;
    chk("model.pipe_stall", 32'(o_pipe_stall), 32'(st && m.valid));
    if (rst || fl)           m = empty_dec();
    else if (!(m.valid && st)) m = ref_decode(inst, pc);
    @(posedge clk);
    #1;
    chk_out("model", m);
  endtask

  logic [31:0] w_add, w_imm00, w_imm01, w_imm11, w_imm10;
  dec_t        e_add;
  vec_t        vt[$];

  initial begin
    w_add   = {5'h01, 1'b0, 4'd3, 4'd1, 4'd2, 14'h0};
    w_imm00 = {5'h01, 1'b1, 4'd3, 4'd1, 1'b0, 1'b0, 16'h8001};
    w_imm01 = {5'h01, 1'b1, 4'd3, 4'd1, 1'b0, 1'b1, 16'h8001};
    w_imm11 = {5'h01, 1'b1, 4'd3, 4'd1, 1'b1, 1'b1, 16'h8001};
    w_imm10 = {5'h01, 1'b1, 4'd3, 4'd1, 1'b1, 1'b0, 16'h8001};
    e_add   = mk(1'b1, 32'h100, 5'h01, 2'd0, 4'd3, 4'd1, 4'd2, 1'b0, 32'h0);

    vt.push_back('{"add_reg", 32'h100, w_add, e_add});
    vt.push_back('{"imm_hz00", 32'h104, w_imm00,
                   mk(1'b1, 32'h104, 5'h01, 2'd0, 4'd3, 4'd1, 4'd0, 1'b1, 32'hFFFF_8001)});
    vt.push_back('{"imm_hz01", 32'h108, w_imm01,
                   mk(1'b1, 32'h108, 5'h01, 2'd0, 4'd3, 4'd1, 4'd0, 1'b1, 32'h0000_8001)});
    vt.push_back('{"imm_hz11", 32'h10C, w_imm11,
                   mk(1'b1, 32'h10C, 5'h01, 2'd0, 4'd3, 4'd1, 4'd0, 1'b1, 32'h8001_0000)});
    vt.push_back('{"imm_hz10", 32'h110, w_imm10,
                   mk(1'b1, 32'h110, 5'h01, 2'd0, 4'd3, 4'd1, 4'd0, 1'b1, 32'h8001_0000)});
    vt.push_back('{"ill_1f", 32'h114, {5'h1F, 27'h7FF_FFFF},
                   mk(1'b1, 32'h114, 5'h1F, 2'd3, 4'd0, 4'd0, 4'd0, 1'b0, 32'h0)});
    vt.push_back('{"ill_op0", 32'h118, 32'h0000_0005,
                   mk(1'b1, 32'h118, 5'h00, 2'd3, 4'd0, 4'd0, 4'd0, 1'b0, 32'h0)});
    vt.push_back('{"bubble", 32'h11C, 32'h0, empty_dec()});
    vt.push_back('{"mem_lw", 32'h120, {5'h08, 1'b1, 4'd7, 4'd15, 2'b00, 16'h0010},
                   mk(1'b1, 32'h120, 5'h08, 2'd1, 4'd7, 4'd15, 4'd0, 1'b1, 32'h0000_0010)});
    vt.push_back('{"br_ret", 32'h124, {5'h0C, 1'b0, 4'd0, 4'd14, 4'd0, 14'h3FFF},
                   mk(1'b1, 32'h124, 5'h0C, 2'd2, 4'd0, 4'd14, 4'd0, 1'b0, 32'h0)});
    vt.push_back('{"sw_neg", 32'h128, {5'h09, 1'b1, 4'd9, 4'd2, 2'b00, 16'hFFFE},
                   mk(1'b1, 32'h128, 5'h09, 2'd1, 4'd9, 4'd2, 4'd0, 1'b1, 32'hFFFF_FFFE)});
    vt.push_back('{"ill_0d", 32'h12C, {5'h0D, 27'h123_4567},
                   mk(1'b1, 32'h12C, 5'h0D, 2'd3, 4'd0, 4'd0, 4'd0, 1'b0, 32'h0)});

    m = empty_dec();
    step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    chk_out("reset", empty_dec());

    foreach (vt[i]) begin
      step(1'b0, 1'b0, 1'b0, vt[i].pc, vt[i].inst);
      chk_out(vt[i].name, vt[i].exp);
    end

    // stall: outputs frozen for 5 cycles while input keeps changing
    step(1'b0, 1'b0, 1'b0, 32'h100, w_add);
    for (int k = 0; k < 5; k++) begin
      step(1'b0, 1'b0, 1'b1, 32'h200 + 32'(k), {5'h02, 27'(k + 1)});
      chk_out("stall_hold", e_add);
      chk("stall.o_pipe_stall", 32'(o_pipe_stall), 32'd1);
    end
    step(1'b0, 1'b0, 1'b0, 32'h204, w_imm00);
    chk_out("stall_release",
            mk(1'b1, 32'h204, 5'h01, 2'd0, 4'd3, 4'd1, 4'd0, 1'b1, 32'hFFFF_8001));

    // flush during stall with a valid word offered
    step(1'b0, 1'b0, 1'b0, 32'h300, w_add);
    step(1'b0, 1'b1, 1'b1, 32'h304, w_add);
    chk_out("flush_in_stall", empty_dec());
    chk("flush.o_pipe_stall", 32'(o_pipe_stall), 32'd0);

    // reset together with flush
    step(1'b0, 1'b0, 1'b0, 32'h308, w_add);
    step(1'b1, 1'b1, 1'b0, 32'h30C, w_add);
    chk_out("reset_flush", empty_dec());

    // reset mid-stall
    step(1'b0, 1'b0, 1'b0, 32'h310, w_add);
    step(1'b1, 1'b0, 1'b1, 32'h314, w_add);
    chk_out("reset_stall", empty_dec());
    chk("reset_stall.o_pipe_stall", 32'(o_pipe_stall), 32'd0);

    // empty stage captures under stall, then reports stall
    step(1'b0, 1'b0, 1'b1, 32'h400, w_add);
    chk_out("empty_capture", mk(1'b1, 32'h400, 5'h01, 2'd0, 4'd3, 4'd1, 4'd2, 1'b0, 32'h0));
    chk("empty_capture.o_pipe_stall", 32'(o_pipe_stall), 32'd1);

    for (int n = 0; n < 2000; n++) begin
      logic [31:0] inst;
      logic [4:0]  opc;
      opc  = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(1, 12));
      inst = {opc, 27'($urandom)};
      if ($urandom_range(0, 7) == 0) inst = 32'h0;
      step($urandom_range(0, 99) == 0, $urandom_range(0, 19) == 0,
           $urandom_range(0, 1) == 1, $urandom, inst);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
